// File: rtl/test_run_sequencer_if.sv
// Control/status bundle between the test-run sequencer (slave) and whoever drives
// its requests and observes the testbench controls and results (master).
interface test_run_sequencer_if;
  logic        start;
  logic        abort;
  logic [31:0] run_length;
  logic [31:0] data_ctr;
  logic [31:0] err_ctr;
  logic        tb_reset;
  logic        tb_enable;
  logic        tb_freeze;
  logic        busy;
  logic        done;
  logic        pass;
  logic        aborted;
  logic        timed_out;
  logic [31:0] result_count;
  logic [31:0] result_errs;

  modport master (
    output start, abort, run_length, data_ctr, err_ctr,
    input  tb_reset, tb_enable, tb_freeze, busy, done, pass, aborted, timed_out,
           result_count, result_errs
  );

  modport slave (
    input  start, abort, run_length, data_ctr, err_ctr,
    output tb_reset, tb_enable, tb_freeze, busy, done, pass, aborted, timed_out,
           result_count, result_errs
  );
endinterface

// File: rtl/test_run_sequencer.sv
// Sequences one testbench run: reset pulse, enable until run_length data points, freeze,
// settle, then latch and report. Optional watchdog: define TEST_RUN_SEQUENCER_TIMEOUT_EN.
module test_run_sequencer #(
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input logic                  clk,
  input logic                  reset,
  test_run_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  // Zero-length phases would underflow the terminal counts above.
  if (RST_CYCLES == 0 || SETTLE_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("test_run_sequencer: cycle parameters must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RSTP   = 3'd1,
    S_RUN    = 3'd2,
    S_FREEZE = 3'd3,
    S_REPORT = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      len_q, len_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      errs_q, errs_d;
  logic             tb_reset_q, tb_reset_d;
  logic             tb_enable_q, tb_enable_d;
  logic             tb_freeze_q, tb_freeze_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             aborted_q, aborted_d;
`ifdef TEST_RUN_SEQUENCER_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic             timed_out_q, timed_out_d;
  logic [31:0]      prev_q, prev_d;
`endif

  // Next-state, counter and result logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    count_d   = count_q;
    errs_d    = errs_q;
    pass_d    = pass_q;
    aborted_d = aborted_q;
    done_d    = 1'b0;
`ifdef TEST_RUN_SEQUENCER_TIMEOUT_EN
    timed_out_d = timed_out_q;
    prev_d      = prev_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          len_d     = bus.run_length;
          pass_d    = 1'b0;
          aborted_d = 1'b0;
`ifdef TEST_RUN_SEQUENCER_TIMEOUT_EN
          timed_out_d = 1'b0;
`endif
          cnt_d     = '0;
          state_d   = S_RSTP;
        end
      end

      S_RSTP: begin
        if (bus.abort) begin
          aborted_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_FREEZE;
        end else if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = (len_q == 32'd0) ? S_FREEZE : S_RUN;
`ifdef TEST_RUN_SEQUENCER_TIMEOUT_EN
          prev_d  = bus.data_ctr;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RUN: begin
        if (bus.abort) begin
          aborted_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_FREEZE;
        end else if (bus.data_ctr >= len_q) begin
          cnt_d   = '0;
          state_d = S_FREEZE;
        end
`ifdef TEST_RUN_SEQUENCER_TIMEOUT_EN
        // Watchdog: cycles since data_ctr last moved, reusing the phase counter.
        else if (bus.data_ctr != prev_q) begin
          prev_d = bus.data_ctr;
          cnt_d  = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timed_out_d = 1'b1;
          aborted_d   = 1'b1;
          cnt_d       = '0;
          state_d     = S_FREEZE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      S_FREEZE: begin
        if (bus.abort) aborted_d = 1'b1;
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_REPORT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_REPORT: begin
        if (bus.abort) aborted_d = 1'b1;
        count_d = bus.data_ctr;
        errs_d  = bus.err_ctr;
        pass_d  = (bus.err_ctr == 32'd0) && !aborted_d;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Control outputs follow the state being entered so they register with it.
  always_comb begin
    tb_reset_d  = (state_d == S_RSTP);
    tb_enable_d = (state_d == S_RUN);
    busy_d      = (state_d != S_IDLE);
    tb_freeze_d = tb_freeze_q;
    case (state_d)
      S_RSTP, S_RUN:     tb_freeze_d = 1'b0;
      S_FREEZE, S_REPORT: tb_freeze_d = 1'b1;
      default:           tb_freeze_d = tb_freeze_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      count_q     <= '0;
      errs_q      <= '0;
      tb_reset_q  <= 1'b0;
      tb_enable_q <= 1'b0;
      tb_freeze_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      count_q     <= count_d;
      errs_q      <= errs_d;
      tb_reset_q  <= tb_reset_d;
      tb_enable_q <= tb_enable_d;
      tb_freeze_q <= tb_freeze_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      aborted_q   <= aborted_d;
    end
  end

`ifdef TEST_RUN_SEQUENCER_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timed_out_q <= 1'b0;
      prev_q      <= '0;
    end else begin
      timed_out_q <= timed_out_d;
      prev_q      <= prev_d;
    end
  end

  assign bus.timed_out = timed_out_q;
`else
  assign bus.timed_out = 1'b0;
`endif

  assign bus.tb_reset     = tb_reset_q;
  assign bus.tb_enable    = tb_enable_q;
  assign bus.tb_freeze    = tb_freeze_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.aborted      = aborted_q;
  assign bus.result_count = count_q;
  assign bus.result_errs  = errs_q;

endmodule

// File: tb/tb_test_run_sequencer.sv
// Bench for test_run_sequencer: table of run scenarios with a result scoreboard,
// plus hand sequences for start+abort in IDLE and asynchronous reset mid-run.
module tb_test_run_sequencer;

  localparam int unsigned RST_CYCLES     = 4;
  localparam int unsigned SETTLE_CYCLES  = 8;
  localparam int unsigned TIMEOUT_CYCLES = 16;
  localparam int          BUDGET         = 3000;

  typedef struct {
    logic [31:0] cmin;
    logic [31:0] cmax;
    logic [31:0] errs;
    bit          pass;
    bit          aborted;
    bit          timed_out;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] len;
    logic [31:0] errs;
    int          abort_mode;  // 0 none, 1 at data_ctr==abort_val, 2 at enabled cycle abort_val
    int          abort_val;
    bit          stall;
    bit          restart;
    int          exp_en;      // -1 when not checked
    logic [31:0] cmin;
    logic [31:0] cmax;
    bit          pass;
    bit          aborted;
    bit          timed_out;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   stall = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  vec_t vecs[6];

  test_run_sequencer_if bus();

  test_run_sequencer #(
    .RST_CYCLES    (RST_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Testbench datapath model: one data point per enabled cycle, cleared by tb_reset.
  always @(negedge clk) begin
    if (reset || bus.tb_reset) bus.data_ctr = 32'd0;
    else if (bus.tb_enable && !stall) bus.data_ctr = bus.data_ctr + 32'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tb_reset"},  32'(bus.tb_reset),  32'd0);
    chk({tag, "_tb_enable"}, 32'(bus.tb_enable), 32'd0);
    chk({tag, "_tb_freeze"}, 32'(bus.tb_freeze), 32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_done"},      32'(bus.done),      32'd0);
    chk({tag, "_pass"},      32'(bus.pass),      32'd0);
    chk({tag, "_aborted"},   32'(bus.aborted),   32'd0);
    chk({tag, "_timed_out"}, 32'(bus.timed_out), 32'd0);
    chk({tag, "_count"},     bus.result_count,   32'd0);
    chk({tag, "_errs"},      bus.result_errs,    32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   t = 0, rst_cnt = 0, en_cnt = 0, t_f = -1;
    bit   got_done = 1'b0, abort_sent = 1'b0;
    logic prev_frz;
    bus.run_length = v.len;
    bus.err_ctr    = v.errs;
    stall          = v.stall;
    bus.start      = 1'b1;
    sb.push_back('{v.cmin, v.cmax, v.errs, v.pass, v.aborted, v.timed_out});
    prev_frz = bus.tb_freeze;
    while (t < BUDGET) begin
      tick();
      t++;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (t == 1)
        chk({v.name, "_entry{busy,rst,frz,en}"},
            32'({bus.busy, bus.tb_reset, bus.tb_freeze, bus.tb_enable}), 32'b1100);
      if (v.restart && t == 2) begin
        bus.start      = 1'b1;
        bus.run_length = 32'd5;
      end
      if (bus.tb_reset) rst_cnt++;
      if (bus.tb_enable) en_cnt++;
      if (bus.tb_freeze && !prev_frz && t_f < 0) t_f = t;
      prev_frz = bus.tb_freeze;
      if (!abort_sent && bus.tb_enable &&
          ((v.abort_mode == 1 && bus.data_ctr == 32'(v.abort_val)) ||
           (v.abort_mode == 2 && en_cnt == v.abort_val))) begin
        bus.abort  = 1'b1;
        abort_sent = 1'b1;
      end
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk({v.name, "_done_seen"}, 32'(got_done), 32'd1);
    chk({v.name, "_tb_reset_cycles"}, 32'(rst_cnt), 32'(RST_CYCLES));
    chk({v.name, "_freeze_to_done"}, 32'(t - t_f), 32'(SETTLE_CYCLES + 1));
    if (v.exp_en >= 0) chk({v.name, "_enable_cycles"}, 32'(en_cnt), 32'(v.exp_en));
    chk({v.name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    if (sb.size() == 0) begin
      chk({v.name, "_scoreboard_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      checks++;
      if (bus.result_count < e.cmin || bus.result_count > e.cmax) begin
        errors++;
        $display("FAIL %s_result_count: got %0d expected %0d..%0d",
                 v.name, bus.result_count, e.cmin, e.cmax);
      end
      chk({v.name, "_result_errs"}, bus.result_errs,       e.errs);
      chk({v.name, "_pass"},        32'(bus.pass),         32'(e.pass));
      chk({v.name, "_aborted"},     32'(bus.aborted),      32'(e.aborted));
      chk({v.name, "_timed_out"},   32'(bus.timed_out),    32'(e.timed_out));
    end
    tick();
    chk({v.name, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    stall = 1'b0;
  endtask

  initial begin
    bit seen_en;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.run_length = 32'd0;
    bus.err_ctr    = 32'd0;

    vecs[0] = '{"normal",     32'd100,  32'd0, 0, 0,  1'b0, 1'b0, 100, 32'd100, 32'd100, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{"errors",     32'd100,  32'd3, 0, 0,  1'b0, 1'b0, 100, 32'd100, 32'd100, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{"zero_len",   32'd0,    32'd0, 0, 0,  1'b0, 1'b0, 0,   32'd0,   32'd0,   1'b1, 1'b0, 1'b0};
    vecs[3] = '{"abort_mid",  32'd1000, 32'd0, 1, 50, 1'b0, 1'b0, -1,  32'd50,  32'd52,  1'b0, 1'b1, 1'b0};
    vecs[4] = '{"start_busy", 32'd20,   32'd0, 0, 0,  1'b0, 1'b1, 20,  32'd20,  32'd20,  1'b1, 1'b0, 1'b0};
`ifdef TEST_RUN_SEQUENCER_TIMEOUT_EN
    vecs[5] = '{"watchdog",   32'd100,  32'd0, 0, 0,  1'b1, 1'b0, 16,  32'd0,   32'd0,   1'b0, 1'b1, 1'b1};
`else
    vecs[5] = '{"stall_abort", 32'd100, 32'd0, 2, 40, 1'b1, 1'b0, 40,  32'd0,   32'd0,   1'b0, 1'b1, 1'b0};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("in_reset");
    #2 reset = 1'b0;
    tick();
    chk_all_zero("after_reset");

    foreach (vecs[i]) run_vec(vecs[i]);

    // start and abort together in IDLE must not launch a run.
    bus.run_length = 32'd10;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_busy", 32'(bus.busy), 32'd0);
    chk("start_abort_tb_reset", 32'(bus.tb_reset), 32'd0);
    tick();
    chk("start_abort_busy_later", 32'(bus.busy), 32'd0);

    // Asynchronous reset in RUN clears every output before the next edge.
    bus.run_length = 32'd1000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    seen_en = 1'b0;
    for (int k = 0; k < 20 && !seen_en; k++) begin
      tick();
      seen_en = bus.tb_enable;
    end
    chk("async_reached_run", 32'(seen_en), 32'd1);
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    #3 reset = 1'b0;
    tick();
    chk("async_post_busy", 32'(bus.busy), 32'd0);
    chk("async_post_freeze", 32'(bus.tb_freeze), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
